// File: rtl/gp9001_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gp9001_op_pkg
//  Purpose  : Shared definitions for the GP9001 command-port arbiter:
//             operation codes, sequencer state encoding, grant indices and
//             the op-code to one-hot strobe decode.
//  Revision : 1.0  initial release
// ============================================================================
package gp9001_op_pkg;

    // Operation codes carried on CPU_OP / DMA_OP
    localparam logic [2:0] OP_NONE        = 3'd0;
    localparam logic [2:0] OP_SELECT_REG  = 3'd1;
    localparam logic [2:0] OP_WRITE_REG   = 3'd2;
    localparam logic [2:0] OP_WRITE_RAM   = 3'd3;
    localparam logic [2:0] OP_READ_RAM_H  = 3'd4;
    localparam logic [2:0] OP_READ_RAM_L  = 3'd5;
    localparam logic [2:0] OP_SET_RAM_PTR = 3'd6;
    localparam logic [2:0] OP_RSVD        = 3'd7;

    // Requester index as reported on GRANT
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Strobe vector bit order:
    //   [0] SELECT_REG [1] WRITE_REG [2] WRITE_RAM
    //   [3] READ_RAM_H [4] READ_RAM_L [5] SET_RAM_PTR
    // NONE and the reserved code decode to all-zero (no GP9001 access).
    function automatic logic [5:0] op_to_strobe(input logic [2:0] op);
        logic [5:0] s;
        s = 6'b000000;
        case (op)
            OP_SELECT_REG:  s = 6'b000001;
            OP_WRITE_REG:   s = 6'b000010;
            OP_WRITE_RAM:   s = 6'b000100;
            OP_READ_RAM_H:  s = 6'b001000;
            OP_READ_RAM_L:  s = 6'b010000;
            OP_SET_RAM_PTR: s = 6'b100000;
            default:        s = 6'b000000;
        endcase
        return s;
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_READ_RAM_H) || (op == OP_READ_RAM_L);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gp9001_op_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : gp9001_rr_pick
//  Purpose  : Two-input request picker (purely combinational).
//             A single requester always wins. On a tie the CPU wins when
//             i_cpu_prio is set, otherwise the side not granted last wins.
//  Ports    : i_cpu_req, i_dma_req  request levels
//             i_last_grant          requester granted most recently
//             i_cpu_prio            fixed CPU priority on ties
//             o_gnt_vld             some request is pending
//             o_gnt_idx             chosen requester (GNT_CPU / GNT_DMA)
//  Revision : 1.0  initial release
// ============================================================================
module gp9001_rr_pick
    import gp9001_op_pkg::*;
(
    input  logic i_cpu_req,
    input  logic i_dma_req,
    input  logic i_last_grant,
    input  logic i_cpu_prio,
    output logic o_gnt_vld,
    output logic o_gnt_idx
);

    always_comb begin
        o_gnt_vld = i_cpu_req | i_dma_req;
        o_gnt_idx = GNT_CPU;
        if (i_cpu_req && i_dma_req) begin
            o_gnt_idx = i_cpu_prio ? GNT_CPU : ~i_last_grant;
        end else if (i_dma_req) begin
            o_gnt_idx = GNT_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gp9001_op_arb.sv
`default_nettype none
// ============================================================================
//  Module   : gp9001_op_arb
//  Purpose  : Arbiter / sequencer for the GP9001 command port shared by the
//             68k decoder (CPU_*) and the sprite/VRAM DMA engine (DMA_*).
//             One op at a time: raise one strobe, hold until GP9001ACK, return
//             read data plus a one-cycle ACK pulse, then wait for GP9001ACK to
//             fall. Missing ACK edges are bounded by TIMEOUT cycles.
//  Ports    : CLK96 / RESET96n       clock, async active-low reset
//             CPU_* / DMA_*          requester ports (REQ, OP, DIN, ACK, DOUT)
//             GP9001_OP_*            one-hot op strobes
//             GP9001_DIN/DOUT/ACK    GP9001 data and level acknowledge
//             GRANT, BUSY            current owner, sequencer not idle
//             TIMEOUT_ERR, ERR_CLR   sticky timeout flag and its clear
//  Revision : 1.0  initial release
// ============================================================================
module gp9001_op_arb
    import gp9001_op_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter int CPU_PRIO = 0
) (
    input  logic        CLK96,
    input  logic        RESET96n,
    input  logic        CPU_REQ,
    input  logic [2:0]  CPU_OP,
    input  logic [15:0] CPU_DIN,
    output logic        CPU_ACK,
    output logic [15:0] CPU_DOUT,
    input  logic        DMA_REQ,
    input  logic [2:0]  DMA_OP,
    input  logic [15:0] DMA_DIN,
    output logic        DMA_ACK,
    output logic [15:0] DMA_DOUT,
    output logic        GP9001_OP_SELECT_REG,
    output logic        GP9001_OP_WRITE_REG,
    output logic        GP9001_OP_WRITE_RAM,
    output logic        GP9001_OP_READ_RAM_H,
    output logic        GP9001_OP_READ_RAM_L,
    output logic        GP9001_OP_SET_RAM_PTR,
    output logic [15:0] GP9001_DIN,
    input  logic [15:0] GP9001_DOUT,
    input  logic        GP9001ACK,
    output logic        GRANT,
    output logic        BUSY,
    output logic        TIMEOUT_ERR,
    input  logic        ERR_CLR
);

    localparam int             CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_CNT_MAX  = CW'(TIMEOUT);
    // Abort at the end of the TIMEOUT-th cycle spent in a state
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic           c_CPU_PRIO = (CPU_PRIO != 0);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt,   w_cnt_nx;
    logic          r_last,  w_last;
    logic          r_grant, w_grant;
    logic [2:0]    r_op,    w_op;
    logic [15:0]   r_din,   w_din;
    logic [5:0]    r_strb,  w_strb;
    logic          r_cpu_ack, w_cpu_ack;
    logic          r_dma_ack, w_dma_ack;
    logic [15:0]   r_cpu_dout, w_cpu_dout;
    logic [15:0]   r_dma_dout, w_dma_dout;
    logic          r_busy,  w_busy;
    logic          r_err,   w_err;
    logic          w_done, w_load, w_err_set;
    logic [15:0]   w_ldata;
    logic          w_pick_vld, w_pick_idx;

    gp9001_rr_pick u_pick (
        .i_cpu_req    (CPU_REQ),
        .i_dma_req    (DMA_REQ),
        .i_last_grant (r_last),
        .i_cpu_prio   (c_CPU_PRIO),
        .o_gnt_vld    (w_pick_vld),
        .o_gnt_idx    (w_pick_idx)
    );

    always_ff @(posedge CLK96 or negedge RESET96n) begin
        if (!RESET96n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        w_last     = r_last;
        w_grant    = r_grant;
        w_op       = r_op;
        w_din      = r_din;
        w_strb     = r_strb;
        w_cpu_ack  = 1'b0;
        w_dma_ack  = 1'b0;
        w_cpu_dout = r_cpu_dout;
        w_dma_dout = r_dma_dout;
        w_done     = 1'b0;
        w_load     = 1'b0;
        w_ldata    = 16'h0000;
        w_err_set  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_pick_vld) begin
                    w_grant    = w_pick_idx;
                    w_last     = w_pick_idx;
                    w_op       = w_pick_idx ? DMA_OP  : CPU_OP;
                    w_din      = w_pick_idx ? DMA_DIN : CPU_DIN;
                    w_strb     = op_to_strobe(w_op);
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_strb == 6'b000000) begin
                    // NONE / reserved: complete without touching the GP9001
                    w_done     = 1'b1;
                    w_state_nx = S_RELEASE;
                    w_cnt_nx   = '0;
                end else if (GP9001ACK) begin
                    w_strb     = 6'b000000;
                    w_done     = 1'b1;
                    w_load     = op_is_read(r_op);
                    w_ldata    = GP9001_DOUT;
                    w_state_nx = S_RELEASE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_strb     = 6'b000000;
                    w_done     = 1'b1;
                    w_load     = 1'b1;
                    w_ldata    = 16'hFFFF;
                    w_err_set  = 1'b1;
                    w_state_nx = S_RELEASE;
                    w_cnt_nx   = '0;
                end
            end
            S_RELEASE: begin
                // Hold off the next grant until the previous ACK has gone low
                if (!GP9001ACK) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_strb     = 6'b000000;
                w_cnt_nx   = '0;
            end
        endcase

        if (w_done) begin
            if (r_grant == GNT_DMA) w_dma_ack = 1'b1;
            else                    w_cpu_ack = 1'b1;
        end
        if (w_load) begin
            if (r_grant == GNT_DMA) w_dma_dout = w_ldata;
            else                    w_cpu_dout = w_ldata;
        end

        w_busy = (w_state_nx != S_IDLE);
        w_err  = w_err_set ? 1'b1 : (ERR_CLR ? 1'b0 : r_err);
    end

    always_ff @(posedge CLK96 or negedge RESET96n) begin
        if (!RESET96n) begin
            r_cnt      <= '0;
            r_last     <= GNT_DMA;
            r_grant    <= GNT_CPU;
            r_op       <= OP_NONE;
            r_din      <= 16'h0000;
            r_strb     <= 6'b000000;
            r_cpu_ack  <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_cpu_dout <= 16'h0000;
            r_dma_dout <= 16'h0000;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last;
            r_grant    <= w_grant;
            r_op       <= w_op;
            r_din      <= w_din;
            r_strb     <= w_strb;
            r_cpu_ack  <= w_cpu_ack;
            r_dma_ack  <= w_dma_ack;
            r_cpu_dout <= w_cpu_dout;
            r_dma_dout <= w_dma_dout;
            r_busy     <= w_busy;
            r_err      <= w_err;
        end
    end

    assign GP9001_OP_SELECT_REG  = r_strb[0];
    assign GP9001_OP_WRITE_REG   = r_strb[1];
    assign GP9001_OP_WRITE_RAM   = r_strb[2];
    assign GP9001_OP_READ_RAM_H  = r_strb[3];
    assign GP9001_OP_READ_RAM_L  = r_strb[4];
    assign GP9001_OP_SET_RAM_PTR = r_strb[5];
    assign GP9001_DIN            = r_din;
    assign CPU_ACK               = r_cpu_ack;
    assign CPU_DOUT              = r_cpu_dout;
    assign DMA_ACK               = r_dma_ack;
    assign DMA_DOUT              = r_dma_dout;
    assign GRANT                 = r_grant;
    assign BUSY                  = r_busy;
    assign TIMEOUT_ERR           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gp9001_op_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gp9001_op_arb
//  Purpose  : Self-checking bench for gp9001_op_arb. Instance A (round-robin,
//             TIMEOUT=8) is checked through a scoreboard of expected
//             completions; instance B (CPU priority) checks tie behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gp9001_op_arb;

    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        cpu_req = 0, dma_req = 0, err_clr = 0;
    logic [2:0]  cpu_op = 0, dma_op = 0;
    logic [15:0] cpu_din = 0, dma_din = 0, gp_dout = 0;
    logic        gp_ack = 0;
    logic        cpu_ack, dma_ack, grant, busy, terr;
    logic [15:0] cpu_dout, dma_dout, gp_din;
    logic        s_sel, s_wreg, s_wram, s_rh, s_rl, s_ptr;
    logic [5:0]  strb_a;
    assign strb_a = {s_ptr, s_rl, s_rh, s_wram, s_wreg, s_sel};

    gp9001_op_arb #(.TIMEOUT(TO), .CPU_PRIO(0)) dut (
        .CLK96(clk), .RESET96n(rst_n),
        .CPU_REQ(cpu_req), .CPU_OP(cpu_op), .CPU_DIN(cpu_din), .CPU_ACK(cpu_ack), .CPU_DOUT(cpu_dout),
        .DMA_REQ(dma_req), .DMA_OP(dma_op), .DMA_DIN(dma_din), .DMA_ACK(dma_ack), .DMA_DOUT(dma_dout),
        .GP9001_OP_SELECT_REG(s_sel), .GP9001_OP_WRITE_REG(s_wreg), .GP9001_OP_WRITE_RAM(s_wram),
        .GP9001_OP_READ_RAM_H(s_rh), .GP9001_OP_READ_RAM_L(s_rl), .GP9001_OP_SET_RAM_PTR(s_ptr),
        .GP9001_DIN(gp_din), .GP9001_DOUT(gp_dout), .GP9001ACK(gp_ack),
        .GRANT(grant), .BUSY(busy), .TIMEOUT_ERR(terr), .ERR_CLR(err_clr)
    );

    // ---------------- instance B (CPU priority) ----------------
    logic        cpu_req_b = 0, dma_req_b = 0;
    logic [2:0]  cpu_op_b = 0, dma_op_b = 0;
    logic [15:0] cpu_din_b = 0, dma_din_b = 0;
    logic        gp_ack_b = 0;
    logic        cpu_ack_b, dma_ack_b, grant_b, busy_b, terr_b;
    logic [15:0] cpu_dout_b, dma_dout_b, gp_din_b;
    logic        b_sel, b_wreg, b_wram, b_rh, b_rl, b_ptr;
    logic [5:0]  strb_b;
    assign strb_b = {b_ptr, b_rl, b_rh, b_wram, b_wreg, b_sel};

    gp9001_op_arb #(.TIMEOUT(TO), .CPU_PRIO(1)) dut_b (
        .CLK96(clk), .RESET96n(rst_n),
        .CPU_REQ(cpu_req_b), .CPU_OP(cpu_op_b), .CPU_DIN(cpu_din_b), .CPU_ACK(cpu_ack_b), .CPU_DOUT(cpu_dout_b),
        .DMA_REQ(dma_req_b), .DMA_OP(dma_op_b), .DMA_DIN(dma_din_b), .DMA_ACK(dma_ack_b), .DMA_DOUT(dma_dout_b),
        .GP9001_OP_SELECT_REG(b_sel), .GP9001_OP_WRITE_REG(b_wreg), .GP9001_OP_WRITE_RAM(b_wram),
        .GP9001_OP_READ_RAM_H(b_rh), .GP9001_OP_READ_RAM_L(b_rl), .GP9001_OP_SET_RAM_PTR(b_ptr),
        .GP9001_DIN(gp_din_b), .GP9001_DOUT(16'h0000), .GP9001ACK(gp_ack_b),
        .GRANT(grant_b), .BUSY(busy_b), .TIMEOUT_ERR(terr_b), .ERR_CLR(1'b0)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- GP9001 models ----------------
    // A: ACK rises once the strobe has been seen for more than gp_dly
    // half-cycle samples; gp_never models a missing ACK.
    int  gp_dly   = 1;
    bit  gp_never = 0;
    int  gp_cnt   = 0;
    always @(negedge clk) begin
        if (strb_a != 6'b0) begin
            gp_cnt = gp_cnt + 1;
            gp_ack = !gp_never && (gp_cnt > gp_dly);
        end else begin
            gp_cnt = 0;
            gp_ack = 1'b0;
        end
    end

    always @(negedge clk) gp_ack_b = (strb_b != 6'b0);

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          who;
        logic [15:0] dout;
        logic [5:0]  strb;
        logic [15:0] din;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_cpu_dout = 16'h0000;
    logic [15:0] exp_dma_dout = 16'h0000;
    int          mon_cyc  = 0;
    logic [5:0]  mon_strb = 6'b0;
    logic [15:0] mon_din  = 16'h0;
    int          viol     = 0;

    task automatic push(input bit who, input logic [2:0] op, input logic [15:0] din);
        exp_t        e;
        logic [15:0] d;
        d      = who ? exp_dma_dout : exp_cpu_dout;
        e.who  = who;
        e.strb = (op >= 3'd1 && op <= 3'd6) ? (6'b000001 << (op - 3'd1)) : 6'b000000;
        e.din  = (e.strb != 6'b0) ? din : 16'h0000;
        if (e.strb == 6'b0) begin
            e.cyc = 0;
        end else if (gp_never) begin
            e.cyc = TO;
            d     = 16'hFFFF;
        end else begin
            e.cyc = gp_dly + 1;
            if (op == 3'd4 || op == 3'd5) d = gp_dout;
        end
        e.dout = d;
        if (who) exp_dma_dout = d; else exp_cpu_dout = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (strb_a != 6'b0) begin
            mon_cyc  = mon_cyc + 1;
            mon_strb = strb_a;
            mon_din  = gp_din;
        end
        if ($countones(strb_a) > 1) viol++;
        if (strb_a != 6'b0 && (cpu_ack || dma_ack)) viol++;
        if (cpu_ack && dma_ack) viol++;
        if (cpu_ack || dma_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_owner", dma_ack, mon_e.who);
                check("grant", grant, mon_e.who);
                check("dout", dma_ack ? dma_dout : cpu_dout, mon_e.dout);
                check("strobe", mon_strb, mon_e.strb);
                check("gp_din", mon_din, mon_e.din);
                check("strobe_cycles", mon_cyc, mon_e.cyc);
            end
            mon_cyc  = 0;
            mon_strb = 6'b0;
            mon_din  = 16'h0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call just after a rising edge. lat = cycles from REQ rise to ACK.
    task automatic do_req(input bit who, input logic [2:0] op, input logic [15:0] din, output int lat);
        int n   = 0;
        bit got = 0;
        if (who) begin dma_op = op; dma_din = din; dma_req = 1'b1; end
        else     begin cpu_op = op; cpu_din = din; cpu_req = 1'b1; end
        while (n < 200 && !got) begin
            @(negedge clk);
            if (who ? dma_ack : cpu_ack) got = 1; else n++;
        end
        if (who) dma_req = 1'b0; else cpu_req = 1'b0;
        if (!got) check(who ? "dma_ack_wait" : "cpu_ack_wait", 0, 1);
        lat = n;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_wait", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int l0, l1, nc, nd, ng, n;
        bit got;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl_a", {strb_a, cpu_ack, dma_ack, grant, busy, terr}, 0);
        check("rst_data_a", {gp_din, cpu_dout, dma_dout}, 0);
        check("rst_ctl_b", {strb_b, cpu_ack_b, dma_ack_b, grant_b, busy_b, terr_b}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous writes from reset: first tie goes to the CPU
        gp_dly = 1;
        push(0, 3'd3, 16'h1234);
        push(1, 3'd3, 16'h5678);
        fork
            do_req(0, 3'd3, 16'h1234, l0);
            do_req(1, 3'd3, 16'h5678, l1);
        join
        check("tie_cpu_latency", l0, 3);
        wait_idle();

        // CPU READ_RAM_H alone, GP ACK two cycles after strobe
        gp_dly  = 2;
        gp_dout = 16'hA55A;
        push(0, 3'd4, 16'h0040);
        do_req(0, 3'd4, 16'h0040, l0);
        check("read_latency", l0, 4);
        wait_idle();

        // Reserved op: no GP9001 access, ACK two cycles after REQ
        push(0, 3'd7, 16'h0BAD);
        do_req(0, 3'd7, 16'h0BAD, l0);
        check("rsvd_latency", l0, 2);
        check("rsvd_no_err", terr, 0);
        wait_idle();

        // DMA READ_RAM_L with the fastest GP9001 response
        gp_dly  = 0;
        gp_dout = 16'h1357;
        push(1, 3'd5, 16'h0002);
        do_req(1, 3'd5, 16'h0002, l1);
        check("dma_read_latency", l1, 2);
        wait_idle();

        // Missing ACK: abort after TO strobe cycles, sticky error, clear
        gp_never = 1;
        push(0, 3'd2, 16'hBEEF);
        do_req(0, 3'd2, 16'hBEEF, l0);
        check("timeout_latency", l0, TO + 1);
        check("timeout_err_set", terr, 1);
        wait_idle();
        check("timeout_err_sticky", terr, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("timeout_err_clr", terr, 0);
        gp_never = 0;

        // CPU priority instance: DMA starves while CPU keeps requesting
        cpu_op_b = 3'd3; cpu_din_b = 16'h1234; cpu_req_b = 1'b1;
        dma_op_b = 3'd3; dma_din_b = 16'h5678; dma_req_b = 1'b1;
        nc = 0; nd = 0; ng = 0;
        repeat (60) begin
            @(negedge clk);
            if (cpu_ack_b) nc++;
            if (dma_ack_b) nd++;
            if (busy_b && grant_b) ng++;
        end
        check("prio_dma_acks", nd, 0);
        check("prio_dma_grants", ng, 0);
        check("prio_cpu_served", (nc >= 15), 1);
        cpu_req_b = 1'b0;
        n = 0; got = 0;
        while (n < 50 && !got) begin
            @(negedge clk);
            if (dma_ack_b) got = 1; else n++;
        end
        dma_req_b = 1'b0;
        check("prio_dma_after_cpu", got, 1);
        wait_idle();

        // Reset asserted while WRITE_REG is on the bus
        gp_never = 1;
        cpu_op = 3'd2; cpu_din = 16'h0F0F; cpu_req = 1'b1;
        n = 0;
        while (n < 10 && !s_wreg) begin
            @(negedge clk);
            n++;
        end
        check("wreg_strobe_up", s_wreg, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_strobe", strb_a, 0);
        check("rst_mid_ctl", {strb_a, cpu_ack, dma_ack, grant, busy, terr}, 0);
        check("rst_mid_data", {gp_din, cpu_dout, dma_dout}, 0);
        cpu_req = 1'b0;
        mon_cyc = 0; mon_strb = 6'b0; mon_din = 16'h0;
        exp_cpu_dout = 16'h0000;
        exp_dma_dout = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        gp_never = 0;
        gp_dly   = 1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 3'd1, 16'h00AA);
        do_req(0, 3'd1, 16'h00AA, l0);
        check("post_reset_latency", l0, 3);
        wait_idle();

        check("protocol_violations", viol, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
